// File: rtl/div_unit_pkg.sv
// Shared CPU definitions for the divider: FSM encodings and the fixed latency.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package div_unit_pkg;

    // Divider FSM encodings; the pipeline stall logic decodes these same values.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Rising edges from the accepting edge (edge 1) to out_valid high.
    localparam int DIV_LATENCY = 33;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: trial-subtract the divisor from the shifted remainder.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the step result is registered.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   partial;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   chosen;
    logic             unused_chosen_msb;

    // Partial remainder shifted left with the next dividend bit appended.
    assign partial = {rem_in, bit_in};

    // Extra top bit catches the borrow of the 33-bit trial subtraction.
    assign diff  = {1'b0, partial} - {2'b00, divisor};
    assign q_bit = ~diff[WIDTH+1];

    // Restore the partial remainder when the subtraction borrowed.
    assign chosen  = q_bit ? diff[WIDTH:0] : partial;
    assign rem_out = chosen[WIDTH-1:0];

    // The restored remainder is always below the divisor, so its MSB is zero.
    assign unused_chosen_msb = chosen[WIDTH];

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned 32-bit divider (quotient and remainder), one bit per cycle.
// Latency: out_valid rises DIV_LATENCY edges after the accepting edge (accept edge counts as 1).
// Backpressure: results held in DONE until out_ready; div_ready only in IDLE; div_flush aborts anywhere.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DIV_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 div_valid,
    output logic                 div_ready,
    input  logic                 div_signed,
    input  logic [DIV_WIDTH-1:0] div_src1,
    input  logic [DIV_WIDTH-1:0] div_src2,
    input  logic                 div_flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DIV_WIDTH-1:0] quot_result,
    output logic [DIV_WIDTH-1:0] rem_result
);

    localparam int               CNT_W    = $clog2(DIV_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_WIDTH - 1);

    div_state_t           state;
    logic [CNT_W-1:0]     cnt;
    logic                 op_signed;
    logic                 sign_a;
    logic                 sign_b;
    logic [DIV_WIDTH-1:0] dvs_mag;
    logic [DIV_WIDTH-1:0] quo_sh;
    logic [DIV_WIDTH-1:0] rem_acc;

    logic [DIV_WIDTH-1:0] mag_a;
    logic [DIV_WIDTH-1:0] mag_b;
    logic [DIV_WIDTH-1:0] rem_nxt;
    logic                 q_bit;
    logic [DIV_WIDTH-1:0] q_next;
    logic [DIV_WIDTH-1:0] q_fix;
    logic [DIV_WIDTH-1:0] r_fix;
    logic                 dvs_zero;

    assign div_ready = (state == IDLE);

    // Operand magnitudes at the request port; only sampled on the accepting edge.
    assign mag_a = (div_signed && div_src1[DIV_WIDTH-1]) ? -div_src1 : div_src1;
    assign mag_b = (div_signed && div_src2[DIV_WIDTH-1]) ? -div_src2 : div_src2;

    // quo_sh starts as the dividend magnitude: its MSB feeds the step while
    // quotient bits shift in from the bottom, so after 32 steps it is the quotient.
    div_step #(
        .WIDTH (DIV_WIDTH)
    ) u_step (
        .rem_in  (rem_acc),
        .bit_in  (quo_sh[DIV_WIDTH-1]),
        .divisor (dvs_mag),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    assign q_next   = {quo_sh[DIV_WIDTH-2:0], q_bit};
    assign dvs_zero = (dvs_mag == '0);

    // Sign fix-up of the final step. Divide-by-zero keeps all-ones unnegated; the
    // remainder already equals |dividend| there, so restoring its sign gives div_src1.
    // The most-negative / -1 case falls out naturally as 0x80000000 remainder 0.
    assign q_fix = dvs_zero                          ? '1 :
                   (op_signed && (sign_a ^ sign_b)) ? -q_next : q_next;
    assign r_fix = (op_signed && sign_a) ? -rem_nxt : rem_nxt;

    // Divider FSM: accept, 32 restoring steps, hold result until consumed; flush aborts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            op_signed   <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            dvs_mag     <= '0;
            quo_sh      <= '0;
            rem_acc     <= '0;
            out_valid   <= 1'b0;
            quot_result <= '0;
            rem_result  <= '0;
        end else if (div_flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_valid) begin
                        op_signed <= div_signed;
                        sign_a    <= div_src1[DIV_WIDTH-1];
                        sign_b    <= div_src2[DIV_WIDTH-1];
                        quo_sh    <= mag_a;
                        dvs_mag   <= mag_b;
                        rem_acc   <= '0;
                        cnt       <= '0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    rem_acc <= rem_nxt;
                    quo_sh  <= q_next;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        quot_result <= q_fix;
                        rem_result  <= r_fix;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
